// File: rtl/fp_au_pkg.sv
// rtl/fp_au_pkg.sv - shared types and constants for the FP arithmetic unit
package fp_au_pkg;

    localparam int INST_W  = 16;
    localparam int MADDR_W = 13;
    localparam int OP_W    = 2;

    localparam logic [INST_W-1:0] HALT_WORD = 16'hFFFF;

    // Instruction field positions: {addr[12:0], wr, op[1:0]}
    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 1;
    localparam int WR_BIT   = 2;
    localparam int ADDR_LSB = 3;
    localparam int ADDR_MSB = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_halt(input logic [INST_W-1:0] w);
        return w == HALT_WORD;
    endfunction

endpackage

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - instruction store, synchronous write, asynchronous read
module inst_mem
    import fp_au_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PC_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PC_W-1:0]   waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [PC_W-1:0]   raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    // Program load; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: FSM, program counter, output registers
module inst_fetch
    import fp_au_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [INST_W-1:0] prog_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              stop,
    output logic [PC_W-1:0]   pc,
    output logic              busy
);

    fetch_state_t state, state_n;

    logic [INST_W-1:0] word;
    logic              mem_we;

    // end_pending: last word of memory was issued, stop lands on the next edge
    logic              end_pending, end_pending_n;
    logic [INST_W-1:0] inst_n;
    logic              inst_valid_n;
    logic              stop_n;
    logic [PC_W-1:0]   pc_n;

    // Writes are locked out while the program is executing
    assign mem_we = prog_we && (state != RUN);

    inst_mem #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (word)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; a held edge never advances the FSM
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (!hold && (end_pending || is_halt(word))) state_n = HALT;
            end
            HALT: begin
                if (start) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values for the fetch registers
    always_comb begin
        inst_n        = inst;
        inst_valid_n  = inst_valid;
        stop_n        = stop;
        pc_n          = pc;
        end_pending_n = end_pending;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_n          = '0;
                    stop_n        = 1'b0;
                    end_pending_n = 1'b0;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (end_pending || is_halt(word)) begin
                        inst_n        = '0;
                        inst_valid_n  = 1'b0;
                        stop_n        = 1'b1;
                        end_pending_n = 1'b0;
                    end else begin
                        inst_n        = word;
                        inst_valid_n  = 1'b1;
                        pc_n          = pc + PC_W'(1);
                        end_pending_n = (pc == PC_W'(DEPTH - 1));
                    end
                end
            end
            default: ;
        endcase
    end

    // Fetch registers; reset clears every output at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst        <= '0;
            inst_valid  <= 1'b0;
            stop        <= 1'b0;
            pc          <= '0;
            end_pending <= 1'b0;
        end else begin
            inst        <= inst_n;
            inst_valid  <= inst_valid_n;
            stop        <= stop_n;
            pc          <= pc_n;
            end_pending <= end_pending_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        hold;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] inst;
    logic        inst_valid;
    logic        stop;
    logic [7:0]  pc;
    logic        busy;

    int n_cmp;
    int n_bad;

    inst_fetch #(
        .DEPTH (256),
        .PC_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold       (hold),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stop       (stop),
        .pc         (pc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int n_issued;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        tick();
        check("rst_inst",  32'(inst), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_stop",  32'(stop), 32'h0);
        check("rst_pc",    32'(pc), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        rst = 1'b1;
        tick();

        // Basic program with a HALT at address 2
        write_word(8'd0, 16'h00D6);
        write_word(8'd1, 16'h0052);
        write_word(8'd2, 16'hFFFF);
        pulse_start();                                  // edge E
        check("e0_busy",  32'(busy), 32'h1);
        check("e0_valid", 32'(inst_valid), 32'h0);
        tick();                                         // E+1
        check("e1_inst",  32'(inst), 32'h00D6);
        check("e1_valid", 32'(inst_valid), 32'h1);
        check("e1_pc",    32'(pc), 32'h1);
        tick();                                         // E+2
        check("e2_inst",  32'(inst), 32'h0052);
        tick();                                         // E+3
        check("e3_stop",  32'(stop), 32'h1);
        check("e3_valid", 32'(inst_valid), 32'h0);
        check("e3_pc",    32'(pc), 32'h2);
        check("e3_busy",  32'(busy), 32'h0);
        tick();
        check("halt_stop_persist", 32'(stop), 32'h1);

        // Restart with a 3-cycle hold after the first issue
        pulse_start();
        check("rs_stop_clear", 32'(stop), 32'h0);
        tick();
        check("h_first", 32'(inst), 32'h00D6);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("h_inst",  32'(inst), 32'h00D6);
            check("h_pc",    32'(pc), 32'h1);
            check("h_valid", 32'(inst_valid), 32'h1);
        end
        hold = 1'b0;
        tick();
        check("h_resume", 32'(inst), 32'h0052);
        check("h_pc2",    32'(pc), 32'h2);
        tick();
        check("h_stop",   32'(stop), 32'h1);

        // Program write during RUN is ignored
        pulse_start();
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h1234;
        tick();
        prog_we = 1'b0;
        check("wr_run_inst", 32'(inst), 32'h00D6);
        tick();
        tick();
        check("wr_run_stop", 32'(stop), 32'h1);
        pulse_start();
        tick();
        check("wr_run_reissue", 32'(inst), 32'h00D6);
        tick();
        tick();
        check("wr_run_stop2", 32'(stop), 32'h1);

        // Start together with a write in HALT: the new word is fetched
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h0052;
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        check("sw_stop_clear", 32'(stop), 32'h0);
        tick();
        check("sw_inst", 32'(inst), 32'h0052);
        tick();
        tick();
        check("sw_stop", 32'(stop), 32'h1);

        // Fill the whole memory: implicit HALT at the end
        for (int a = 0; a < 256; a++) write_word(8'(a), 16'h0001);
        pulse_start();
        n_issued = 0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (inst_valid === 1'b1 && inst === 16'h0001) n_issued++;
            if (k == 255) check("fill_e255_pc", 32'(pc), 32'd255);
            if (k == 256) check("fill_e256_stop", 32'(stop), 32'h0);
        end
        check("fill_issued", 32'(n_issued), 32'd256);
        check("fill_pc_wrap", 32'(pc), 32'h0);
        tick();                                         // E+257
        check("fill_stop", 32'(stop), 32'h1);
        check("fill_valid", 32'(inst_valid), 32'h0);
        check("fill_pc", 32'(pc), 32'h0);
        check("fill_busy", 32'(busy), 32'h0);

        // Asynchronous reset mid-RUN at pc=5
        pulse_start();
        for (int k = 0; k < 5; k++) tick();
        check("ar_pc_before", 32'(pc), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check("ar_inst",  32'(inst), 32'h0);
        check("ar_valid", 32'(inst_valid), 32'h0);
        check("ar_stop",  32'(stop), 32'h0);
        check("ar_pc",    32'(pc), 32'h0);
        check("ar_busy",  32'(busy), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("ar_idle_busy", 32'(busy), 32'h0);
        pulse_start();
        tick();
        check("ar_rerun_inst", 32'(inst), 32'h0001);
        check("ar_rerun_pc",   32'(pc), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the data-access stage in the 64-bit FP arithmetic unit. Holds a small program of 16-bit instructions, loaded through a write port. On `start` it steps a program counter through the program and presents one instruction per cycle on `inst`. A HALT word or end of memory raises `stop` to freeze the data-access stage.

## Interface
- `DEPTH`, 256: instruction memory depth in 16-bit words; power of two.
- `PC_W`, 8: program-counter width, equal to log2(`DEPTH`).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins execution from address 0.
- `hold`  in  1  downstream stall; freezes the fetch outputs and the PC.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  PC_W  program write address.
- `prog_data`  in  16  program word, format {addr[12:0], wr, op[1:0]}.
- `inst`  out  16  current instruction to the data-access stage.
- `inst_valid`  out  1  `inst` carries a real instruction this cycle.
- `stop`  out  1  program finished; drives data-access `stop`.
- `pc`  out  PC_W  address of the next word to fetch.
- `busy`  out  1  state is RUN.

## Operation
- States: IDLE, RUN, HALT.
- Reset drives IDLE, `inst`=0, `inst_valid`=0, `stop`=0, `pc`=0, `busy`=0. Memory contents are not cleared.
- IDLE:
  - `start`=1 moves to RUN with `pc`=0.
  - `prog_we` writes `prog_data` to `prog_addr`.
- RUN, `hold`=0, word w = mem[pc]:
  - If w is the HALT word 16'hFFFF: `inst`<=0, `inst_valid`<=0, `stop`<=1, go to HALT; `pc` holds its value.
  - Otherwise: `inst`<=w, `inst_valid`<=1, `pc`<=pc+1.
  - If pc = DEPTH-1 and w is not HALT: issue w, then go to HALT. `pc` wraps to 0 and `stop` asserts on the following edge. This is an implicit HALT, so `pc` never fetches past the end.
- RUN, `hold`=1: `inst`, `inst_valid`, `pc` and state all hold. A HALT is only detected on a non-held edge.
- HALT:
  - `stop`=1 and `inst_valid`=0 persist.
  - `start` re-enters RUN from `pc`=0 and clears `stop` on the same edge.
  - `prog_we` is accepted.
- `prog_we` in RUN is ignored; memory is unchanged.
- `start` in RUN is ignored.
- `prog_we` and `start` on the same edge (IDLE/HALT): the write lands first, so the first fetch sees the new word.

## Timing
- Memory read is combinational from `pc`; `inst` is registered, giving 1-cycle latency.
- Edge E accepts `start`; edge E+1 presents mem[0]; edge E+k presents mem[k-1].
- Throughput is one instruction per non-held cycle.
- With HALT at address n, `stop` rises on edge E+n+1, the same edge that drops `inst_valid`.
- `stop` is registered and glitch-free; it stays high until `start` or reset.
- `rst` low mid-RUN clears all outputs immediately and asynchronously. After release the block sits in IDLE until `start`.

## Structure
- Shared package `fp_au_pkg`:
  - `INST_W`=16, `MADDR_W`=13, `OP_W`=2
  - `HALT_WORD`=16'hFFFF
  - field-slice positions (op [1:0], wr [2], addr [15:3])
  - fetch state enum {IDLE, RUN, HALT}
- One sub-module, `inst_mem`: DEPTH×16 array with a synchronous write port and an asynchronous read port.
- FSM, PC and output registers live in `inst_fetch`.

## Test plan
- Program mem[0]={13'd26,1'b1,2'b10}, mem[1]={13'd10,1'b0,2'b10}, mem[2]=16'hFFFF, then pulse `start`:
  - `inst`=16'h00D6 on E+1, 16'h0052 on E+2;
  - E+3: `stop`=1, `inst_valid`=0, `pc`=2.
- Same program with `hold`=1 on cycle E+1 for 3 cycles: `inst` stays 16'h00D6 and `pc`=1 throughout; the sequence then resumes unchanged.
- Fill all 256 words with 16'h0001 and start:
  - 256 valid instructions issue;
  - `stop` rises on E+257 and `pc` wraps to 0.
- `prog_we` writing 16'h1234 to addr 0 during RUN: mem[0] is unchanged; a restart from HALT reissues the original word.
- Assert `rst` low mid-RUN at `pc`=5: all outputs are 0 immediately. After release, `start` reruns from address 0 with memory intact.
- `start` together with `prog_we` (addr 0, 16'h0052) in HALT: `stop` clears on that edge and the first issued `inst`=16'h0052.
